// File: rtl/ahb_protocol_monitor.sv
// ahb_protocol_monitor
// Watches one AHB-Lite manager/subordinate link and reports protocol rule
// violations as a registered one-cycle event, sticky per-code flags and a
// saturating violation counter. Burst state, stall history, wait-state count
// and the ERROR response sequence are all tracked in RTL.
//
// Ports
//   hclk          clock, all logic on the rising edge
//   hrst          synchronous active-low reset
//   haddr         address-phase address
//   hburst        burst type (SINGLE, INCR, WRAP4, INCR4, ... INCR16)
//   hsize         transfer size, bytes = 1 << hsize, values above 2 act as 2
//   htrans        IDLE / BUSY / NONSEQ / SEQ
//   hwrite        transfer direction
//   hreadyout     subordinate ready
//   hresp         bit 0 = ERROR, bit 1 ignored
//   sticky_clr    clears sticky_flags and viol_cnt
//   viol_valid    one-cycle pulse for an edge with any enabled violation
//   viol_code     lowest-numbered violation code on that edge
//   viol_addr     haddr captured on the offending edge
//   sticky_flags  bit n set by violation code n+1
//   viol_cnt      saturating count of violating edges
//
// Violation codes: 1 ALIGN, 2 SEQ_NO_BURST, 3 ADDR_SEQ, 4 CTRL_CHANGE,
// 5 STALL_CHANGE, 6 WAIT_TIMEOUT, 7 ERR_RESP, 8 BURST_LEN.

module ahb_protocol_monitor #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 16,
    parameter logic [7:0]  CHECK_EN = 8'hFF
) (
    input  logic              hclk,
    input  logic              hrst,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [2:0]        hburst,
    input  logic [2:0]        hsize,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic              hreadyout,
    input  logic [1:0]        hresp,
    input  logic              sticky_clr,
    output logic              viol_valid,
    output logic [3:0]        viol_code,
    output logic [ADDR_W-1:0] viol_addr,
    output logic [7:0]        sticky_flags,
    output logic [CNT_W-1:0]  viol_cnt
);

    localparam logic [1:0] HT_IDLE   = 2'd0;
    localparam logic [1:0] HT_BUSY   = 2'd1;
    localparam logic [1:0] HT_NONSEQ = 2'd2;
    localparam logic [1:0] HT_SEQ    = 2'd3;
    localparam logic [2:0] HB_SINGLE = 3'd0;

    localparam int unsigned WAIT_W   = 9;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        ERR_OKAY,
        ERR_ERR1,
        ERR_ERR2
    } err_state_t;

    function automatic logic [1:0] eff_size(input logic [2:0] s);
        return (s > 3'd2) ? 2'd2 : s[1:0];
    endfunction

    // Bus decode
    logic is_idle, is_busy, is_ns, is_seq, is_act, acc_ns, acc_seq;
    logic resp_unused;

    assign is_idle     = (htrans == HT_IDLE);
    assign is_busy     = (htrans == HT_BUSY);
    assign is_ns       = (htrans == HT_NONSEQ);
    assign is_seq      = (htrans == HT_SEQ);
    assign is_act      = is_ns || is_seq;
    assign acc_ns      = hreadyout && is_ns;
    assign acc_seq     = hreadyout && is_seq;
    assign resp_unused = hresp[1];

    // Burst tracker state
    logic              b_open;
    logic [2:0]        b_burst;
    logic [2:0]        b_size;
    logic              b_write;
    logic [ADDR_W-1:0] b_addr;
    logic [4:0]        b_beat;

    // Stall history
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic              st_write;
    logic [2:0]        st_size;

    // Data phase / wait counting
    logic              dp_valid;
    logic [WAIT_W-1:0] wait_cnt;

    // ERROR response FSM
    err_state_t err_state, err_next;
    logic       err_viol;

    // Derived burst values
    logic [ADDR_W-1:0] cur_bytes, b_bytes, bnd_mask, inc_addr, exp_addr;
    logic [4:0]        b_len;
    logic [2:0]        len_sh;
    logic              b_fixed, b_wrap;

    always_comb begin
        cur_bytes = ADDR_W'(1) << eff_size(hsize);
        b_bytes   = ADDR_W'(1) << eff_size(b_size);
        b_len     = 5'd0;
        len_sh    = 3'd0;
        case (b_burst)
            3'd2, 3'd3: begin b_len = 5'd4;  len_sh = 3'd2; end
            3'd4, 3'd5: begin b_len = 5'd8;  len_sh = 3'd3; end
            3'd6, 3'd7: begin b_len = 5'd16; len_sh = 3'd4; end
            default:    begin b_len = 5'd0;  len_sh = 3'd0; end
        endcase
        b_fixed  = b_burst[2] || b_burst[1];
        b_wrap   = b_fixed && !b_burst[0];
        // Wrap boundary is beats * bytes; mask selects the offset within it.
        bnd_mask = (b_bytes << len_sh) - ADDR_W'(1);
        inc_addr = b_addr + b_bytes;
        exp_addr = b_wrap ? ((b_addr & ~bnd_mask) | (inc_addr & bnd_mask)) : inc_addr;
    end

    // ERROR response FSM: next state and violation
    always_comb begin
        err_next = ERR_OKAY;
        err_viol = 1'b0;
        case (err_state)
            ERR_ERR1: begin
                if (hresp[0] && hreadyout) begin
                    err_next = ERR_ERR2;
                end else begin
                    err_viol = 1'b1;
                    err_next = ERR_OKAY;
                end
            end
            default: begin
                if (hresp[0] && !hreadyout) begin
                    err_next = ERR_ERR1;
                end else if (hresp[0] && hreadyout) begin
                    err_viol = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hrst) begin
            err_state <= ERR_OKAY;
        end else begin
            err_state <= err_next;
        end
    end

    // Rule evaluation
    logic [7:0]       raw, masked;
    logic             any_viol;
    logic [3:0]       code_lo;
    logic             stall_chg, short_end, over_run;
    logic [CNT_W-1:0] cnt_base, cnt_next;

    always_comb begin
        stall_chg = st_valid &&
                    ((is_act && (haddr != st_addr || hwrite != st_write || hsize != st_size)) ||
                     is_idle);
        short_end = b_open && b_fixed && (b_beat < b_len) && !hresp[0] &&
                    hreadyout && (is_idle || is_ns);
        // A completed fixed burst stays registered so an extra SEQ reports
        // code 8 rather than code 2.
        over_run  = acc_seq && b_open && b_fixed && (b_beat >= b_len);

        raw    = '0;
        raw[0] = is_act && ((haddr & (cur_bytes - ADDR_W'(1))) != '0);
        raw[1] = (is_seq || is_busy) && (!b_open || b_burst == HB_SINGLE);
        raw[2] = acc_seq && b_open && (b_burst != HB_SINGLE) && (haddr != exp_addr);
        raw[3] = (is_seq || is_busy) && b_open &&
                 (hburst != b_burst || hsize != b_size || hwrite != b_write);
        raw[4] = stall_chg;
        raw[5] = dp_valid && !hreadyout && (wait_cnt == WAIT_LIM);
        raw[6] = err_viol;
        raw[7] = short_end || over_run;

        masked   = raw & CHECK_EN;
        any_viol = |masked;

        code_lo = 4'd0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (masked[i] && code_lo == 4'd0) begin
                code_lo = 4'(i + 1);
            end
        end

        cnt_base = sticky_clr ? '0 : viol_cnt;
        cnt_next = (any_viol && cnt_base != '1) ? cnt_base + CNT_W'(1) : cnt_base;
    end

    // Burst tracker
    always_ff @(posedge hclk) begin
        if (!hrst) begin
            b_open  <= 1'b0;
            b_burst <= '0;
            b_size  <= '0;
            b_write <= 1'b0;
            b_addr  <= '0;
            b_beat  <= '0;
        end else begin
            if (acc_ns) begin
                b_open  <= 1'b1;
                b_burst <= hburst;
                b_size  <= hsize;
                b_write <= hwrite;
                b_addr  <= haddr;
                b_beat  <= 5'd1;
            end else if (hresp[0]) begin
                b_open <= 1'b0;
            end else if (hreadyout && is_idle) begin
                b_open <= 1'b0;
            end else if (acc_seq && b_open) begin
                b_addr <= haddr;
                if (!(b_fixed && b_beat >= b_len) && b_beat != 5'd31) begin
                    b_beat <= b_beat + 5'd1;
                end
            end
        end
    end

    // Stall history and wait-state counting
    always_ff @(posedge hclk) begin
        if (!hrst) begin
            st_valid <= 1'b0;
            st_addr  <= '0;
            st_write <= 1'b0;
            st_size  <= '0;
            dp_valid <= 1'b0;
            wait_cnt <= '0;
        end else begin
            st_valid <= !hreadyout && is_act;
            st_addr  <= haddr;
            st_write <= hwrite;
            st_size  <= hsize;

            if (hreadyout) begin
                dp_valid <= acc_ns || acc_seq;
                wait_cnt <= '0;
            end else if (dp_valid && wait_cnt <= WAIT_LIM) begin
                // Counter stops one past the limit so the timeout reports once.
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

    // Registered outputs
    always_ff @(posedge hclk) begin
        if (!hrst) begin
            viol_valid   <= 1'b0;
            viol_code    <= '0;
            viol_addr    <= '0;
            sticky_flags <= '0;
            viol_cnt     <= '0;
        end else begin
            viol_valid   <= any_viol;
            viol_code    <= code_lo;
            if (any_viol) begin
                viol_addr <= haddr;
            end
            sticky_flags <= (sticky_clr ? 8'h00 : sticky_flags) | masked;
            viol_cnt     <= cnt_next;
        end
    end

endmodule

// File: tb/tb_ahb_protocol_monitor.sv
// Directed bench for ahb_protocol_monitor (CNT_W reduced to 4 so the
// saturation case stays short).

module tb_ahb_protocol_monitor;

    logic        hclk = 1'b0;
    logic        hrst;
    logic [31:0] haddr;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        hwrite;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic        sticky_clr;
    logic        viol_valid;
    logic [3:0]  viol_code;
    logic [31:0] viol_addr;
    logic [7:0]  sticky_flags;
    logic [3:0]  viol_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 hclk = ~hclk;

    ahb_protocol_monitor #(
        .ADDR_W   (32),
        .MAX_WAIT (16),
        .CNT_W    (4),
        .CHECK_EN (8'hFF)
    ) dut (
        .hclk         (hclk),
        .hrst         (hrst),
        .haddr        (haddr),
        .hburst       (hburst),
        .hsize        (hsize),
        .htrans       (htrans),
        .hwrite       (hwrite),
        .hreadyout    (hreadyout),
        .hresp        (hresp),
        .sticky_clr   (sticky_clr),
        .viol_valid   (viol_valid),
        .viol_code    (viol_code),
        .viol_addr    (viol_addr),
        .sticky_flags (sticky_flags),
        .viol_cnt     (viol_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [3:0] c,
                              input logic [7:0] f, input logic [3:0] n);
        check({tag, ".valid"}, {31'd0, viol_valid}, {31'd0, v});
        check({tag, ".code"},  {28'd0, viol_code},  {28'd0, c});
        check({tag, ".flags"}, {24'd0, sticky_flags}, {24'd0, f});
        check({tag, ".cnt"},   {28'd0, viol_cnt},   {28'd0, n});
    endtask

    // Drive one edge worth of bus inputs, then sample 1 time unit after the edge.
    task automatic bus(input logic [1:0] t, input logic [31:0] a, input logic [2:0] b,
                       input logic rdy, input logic [1:0] r);
        htrans    = t;
        haddr     = a;
        hburst    = b;
        hreadyout = rdy;
        hresp     = r;
        @(posedge hclk);
        #1;
    endtask

    initial begin
        hrst = 1'b0; haddr = '0; hburst = '0; hsize = 3'd2; htrans = 2'd0;
        hwrite = 1'b0; hreadyout = 1'b1; hresp = 2'd0; sticky_clr = 1'b0;

        // Reset state
        bus(2'd0, 32'h0, 3'd0, 1'b1, 2'd0);
        bus(2'd0, 32'h0, 3'd0, 1'b1, 2'd0);
        expect_out("reset", 1'b0, 4'd0, 8'h00, 4'd0);
        check("reset.addr", viol_addr, 32'h0);
        hrst = 1'b1;

        // Clean INCR4 at 0x100
        bus(2'd2, 32'h100, 3'd3, 1'b1, 2'd0); check("incr4.b0", {31'd0, viol_valid}, 32'd0);
        bus(2'd3, 32'h104, 3'd3, 1'b1, 2'd0); check("incr4.b1", {31'd0, viol_valid}, 32'd0);
        bus(2'd3, 32'h108, 3'd3, 1'b1, 2'd0); check("incr4.b2", {31'd0, viol_valid}, 32'd0);
        bus(2'd3, 32'h10C, 3'd3, 1'b1, 2'd0); check("incr4.b3", {31'd0, viol_valid}, 32'd0);
        bus(2'd0, 32'h0,   3'd0, 1'b1, 2'd0);
        expect_out("incr4.end", 1'b0, 4'd0, 8'h00, 4'd0);

        // Clean WRAP4 at 0x38
        bus(2'd2, 32'h38, 3'd2, 1'b1, 2'd0);
        bus(2'd3, 32'h3C, 3'd2, 1'b1, 2'd0); check("wrap4.b1", {31'd0, viol_valid}, 32'd0);
        bus(2'd3, 32'h30, 3'd2, 1'b1, 2'd0); check("wrap4.b2", {31'd0, viol_valid}, 32'd0);
        bus(2'd3, 32'h34, 3'd2, 1'b1, 2'd0); check("wrap4.b3", {31'd0, viol_valid}, 32'd0);
        bus(2'd0, 32'h0,  3'd0, 1'b1, 2'd0);
        expect_out("wrap4.end", 1'b0, 4'd0, 8'h00, 4'd0);

        // WRAP4 with a wrong last address
        bus(2'd2, 32'h38, 3'd2, 1'b1, 2'd0);
        bus(2'd3, 32'h3C, 3'd2, 1'b1, 2'd0);
        bus(2'd3, 32'h30, 3'd2, 1'b1, 2'd0);
        bus(2'd3, 32'h40, 3'd2, 1'b1, 2'd0);
        expect_out("wrap4bad", 1'b1, 4'd3, 8'h04, 4'd1);
        check("wrap4bad.addr", viol_addr, 32'h40);
        bus(2'd0, 32'h0, 3'd0, 1'b1, 2'd0);
        expect_out("wrap4bad.pulse", 1'b0, 4'd0, 8'h04, 4'd1);

        // Wait timeout: one accepted NONSEQ, then 19 low-ready edges
        bus(2'd2, 32'h200, 3'd0, 1'b1, 2'd0);
        check("wait.accept", {31'd0, viol_valid}, 32'd0);
        for (int i = 1; i <= 19; i++) begin
            bus(2'd0, 32'h200, 3'd0, 1'b0, 2'd0);
            check($sformatf("wait.e%0d", i), {31'd0, viol_valid}, {31'd0, (i == 17)});
            if (i == 17) begin
                expect_out("wait.timeout", 1'b1, 4'd6, 8'h24, 4'd2);
                check("wait.addr", viol_addr, 32'h200);
            end
        end
        bus(2'd0, 32'h0, 3'd0, 1'b1, 2'd0);
        expect_out("wait.end", 1'b0, 4'd0, 8'h24, 4'd2);

        // ERROR with one cycle only
        bus(2'd0, 32'h0, 3'd0, 1'b0, 2'd1);
        check("err1.first", {31'd0, viol_valid}, 32'd0);
        bus(2'd0, 32'h0, 3'd0, 1'b1, 2'd0);
        expect_out("err1.bad", 1'b1, 4'd7, 8'h64, 4'd3);

        // Correct two-cycle ERROR inside INCR8, then IDLE
        bus(2'd2, 32'h0, 3'd5, 1'b1, 2'd0); check("err2.ns",  {31'd0, viol_valid}, 32'd0);
        bus(2'd3, 32'h4, 3'd5, 1'b1, 2'd0); check("err2.seq", {31'd0, viol_valid}, 32'd0);
        bus(2'd0, 32'h0, 3'd0, 1'b0, 2'd1); check("err2.c1",  {31'd0, viol_valid}, 32'd0);
        bus(2'd0, 32'h0, 3'd0, 1'b1, 2'd1); check("err2.c2",  {31'd0, viol_valid}, 32'd0);
        bus(2'd0, 32'h0, 3'd0, 1'b1, 2'd0);
        expect_out("err2.end", 1'b0, 4'd0, 8'h64, 4'd3);

        // Misaligned NONSEQ with an address change while stalled
        sticky_clr = 1'b1;
        bus(2'd0, 32'h0, 3'd0, 1'b1, 2'd0);
        expect_out("clr1", 1'b0, 4'd0, 8'h00, 4'd0);
        sticky_clr = 1'b0;
        bus(2'd2, 32'h100, 3'd0, 1'b0, 2'd0);
        check("align.stall", {31'd0, viol_valid}, 32'd0);
        bus(2'd2, 32'h102, 3'd0, 1'b1, 2'd0);
        expect_out("align", 1'b1, 4'd1, 8'h11, 4'd1);
        check("align.addr", viol_addr, 32'h102);
        sticky_clr = 1'b1;
        bus(2'd0, 32'h0, 3'd0, 1'b1, 2'd0);
        expect_out("clr2", 1'b0, 4'd0, 8'h00, 4'd0);

        // Clear and violation on the same edge
        bus(2'd3, 32'h0, 3'd0, 1'b1, 2'd0);
        expect_out("clr_viol", 1'b1, 4'd2, 8'h02, 4'd1);

        // Counter saturation: 2^4+3 violating edges
        bus(2'd0, 32'h0, 3'd0, 1'b1, 2'd0);
        expect_out("clr3", 1'b0, 4'd0, 8'h00, 4'd0);
        sticky_clr = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            bus(2'd3, 32'h0, 3'd0, 1'b1, 2'd0);
            check($sformatf("sat.cnt%0d", i), {28'd0, viol_cnt}, (i < 15) ? i : 15);
        end
        expect_out("sat.end", 1'b1, 4'd2, 8'h02, 4'd15);

        // Reset in the middle of an INCR16, then SEQ
        bus(2'd0, 32'h0,   3'd0, 1'b1, 2'd0);
        bus(2'd2, 32'h300, 3'd7, 1'b1, 2'd0); check("rst.b0", {31'd0, viol_valid}, 32'd0);
        bus(2'd3, 32'h304, 3'd7, 1'b1, 2'd0); check("rst.b1", {31'd0, viol_valid}, 32'd0);
        bus(2'd3, 32'h308, 3'd7, 1'b1, 2'd0); check("rst.b2", {31'd0, viol_valid}, 32'd0);
        hrst = 1'b0;
        bus(2'd3, 32'h30C, 3'd7, 1'b1, 2'd0);
        expect_out("rst.mid", 1'b0, 4'd0, 8'h00, 4'd0);
        check("rst.mid.addr", viol_addr, 32'h0);
        hrst = 1'b1;
        bus(2'd3, 32'h310, 3'd7, 1'b1, 2'd0);
        expect_out("rst.seq", 1'b1, 4'd2, 8'h02, 4'd1);
        check("rst.seq.addr", viol_addr, 32'h310);
        bus(2'd0, 32'h0, 3'd0, 1'b1, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
